// File: rtl/alu_pipe.sv
// Two-stage pipelined N-bit ALU with valid/ready handshakes, status flags and an accumulator.
// S1 holds the operand bundle; S2 holds the registered result, flags and accumulator.
module alu_pipe #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   opcode,
    input  logic         acc_sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Y,
    output logic [3:0]   flags
);

    localparam int unsigned SHW = $clog2(N);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    op_e          op_q, op_d;
    logic         acc_sel_q, acc_sel_d;
    logic         s1_valid_q, s1_valid_d;
    logic [N-1:0] y_q, y_d;
    logic [3:0]   flags_q, flags_d;
    logic         s2_valid_q, s2_valid_d;
    logic [N-1:0] acc_q, acc_d;

    logic         s1_load;
    logic         s2_load;
    logic [N-1:0] a_eff;
    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [N-1:0] res;
    logic         carry;
    logic         ovf;

    // Handshake: in_ready depends only on registered state and out_ready.
    always_comb begin
        in_ready = !s1_valid_q || !s2_valid_q || out_ready;
        s1_load  = in_valid && in_ready;
        s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    end

    // Result and flag computation from the S1 registers.
    always_comb begin
        a_eff = acc_sel_q ? acc_q : a_q;
        sum   = {1'b0, a_eff} + {1'b0, b_q};
        diff  = {1'b0, a_eff} - {1'b0, b_q};
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res   = sum[N-1:0];
                carry = sum[N];
                ovf   = (a_eff[N-1] == b_q[N-1]) && (sum[N-1] != a_eff[N-1]);
            end
            OP_SUB: begin
                res   = diff[N-1:0];
                carry = diff[N];
                ovf   = (a_eff[N-1] != b_q[N-1]) && (diff[N-1] != a_eff[N-1]);
            end
            OP_AND: res = a_eff & b_q;
            OP_OR:  res = a_eff | b_q;
            OP_XOR: res = a_eff ^ b_q;
            OP_NOT: res = ~a_eff;
            OP_SHL: res = (b_q >= N'(N)) ? '0 : (a_eff << b_q[SHW-1:0]);
            OP_SHR: res = (b_q >= N'(N)) ? '0 : (a_eff >> b_q[SHW-1:0]);
        endcase
    end

    // Next-state for both stages; acc follows every S1->S2 transfer.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        acc_sel_d  = acc_sel_q;
        y_d        = y_q;
        flags_d    = flags_q;
        acc_d      = acc_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;

        if (s1_load) begin
            a_d       = A;
            b_d       = B;
            op_d      = op_e'(opcode);
            acc_sel_d = acc_sel;
        end
        if (s1_load) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            y_d        = res;
            flags_d    = {ovf, carry, res[N-1], (res == '0)};
            acc_d      = res;
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            acc_sel_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            y_q        <= '0;
            flags_q    <= 4'b0001;
            acc_q      <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            acc_sel_q  <= acc_sel_d;
            s1_valid_q <= s1_valid_d;
            y_q        <= y_d;
            flags_q    <= flags_d;
            acc_q      <= acc_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign Y         = y_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes expected {Y, flags}, monitor pops on each output handshake.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] opcode;
    logic       acc_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Y;
    logic [3:0] flags;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int num_acc = 0;
    logic [11:0] exp_q[$];
    int out_cyc_q[$];
    int acc_cyc_q[$];
    logic bp_done;
    logic rnd_done;
    logic [7:0] mdl_acc;

    alu_pipe #(.N(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .acc_sel(acc_sel),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output handshake pops one expected bundle.
    always @(negedge clk) begin
        logic [11:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got Y=%0d with no expected entry", Y);
            end else begin
                e = exp_q.pop_front();
                check("out_y", 32'(Y), 32'(e[11:4]));
                check("out_flags", 32'(flags), 32'(e[3:0]));
            end
            out_cyc_q.push_back(cyc);
        end
    end

    // Starts at posedge+1, returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic acc, input logic [7:0] ey, input logic [3:0] ef);
        int n = 0;
        in_valid = 1'b1;
        A = a; B = b; opcode = op; acc_sel = acc;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%0d expected 1", in_ready);
        end else begin
            exp_q.push_back({ey, ef});
            acc_cyc_q.push_back(cyc);
            num_acc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        align();
    endtask

    // Reset pulse with garbage on in_valid, then checks the post-reset state.
    task automatic do_reset();
        align();
        rst = 1'b1;
        in_valid = 1'b1; A = 8'hA5; B = 8'h3C; opcode = 3'd0; acc_sel = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(Y), 32'd0);
        check("rst_flags", 32'(flags), 32'b0001);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        align();
    endtask

    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int s;
        logic [7:0] y;
        logic c, v;
        c = 1'b0; v = 1'b0; y = 8'd0;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b);
                y = 8'(s % 256);
                c = (s > 255);
                v = ((a >= 128) == (b >= 128)) && ((y >= 128) != (a >= 128));
            end
            3'd1: begin
                s = int'(a) - int'(b) + 256;
                y = 8'(s % 256);
                c = (a < b);
                v = ((a >= 128) != (b >= 128)) && ((y >= 128) != (a >= 128));
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~a;
            3'd6: y = (b >= 8) ? 8'd0 : 8'((int'(a) << b) % 256);
            default: y = (b >= 8) ? 8'd0 : 8'(int'(a) >> b);
        endcase
        return {y, v, c, y[7], (y == 8'd0)};
    endfunction

    initial begin
        logic [11:0] r;
        logic [7:0] ra, rb, aeff;
        logic [2:0] rop;
        logic racc;
        int n;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; opcode = '0; acc_sel = 1'b0; out_ready = 1'b1;
        bp_done = 1'b0; rnd_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_flags", 32'(flags), 32'b0001);
        check("init_in_ready", 32'(in_ready), 32'd1);
        align();

        // All opcodes back-to-back, then flag corner cases.
        out_cyc_q.delete(); acc_cyc_q.delete();
        send(8'd73, 8'd42, 3'd0, 1'b0, 8'd115, 4'b0000);
        send(8'd73, 8'd42, 3'd1, 1'b0, 8'd31,  4'b0000);
        send(8'd73, 8'd42, 3'd2, 1'b0, 8'd8,   4'b0000);
        send(8'd73, 8'd42, 3'd3, 1'b0, 8'd107, 4'b0000);
        send(8'd73, 8'd42, 3'd4, 1'b0, 8'd99,  4'b0000);
        send(8'd73, 8'd42, 3'd5, 1'b0, 8'd182, 4'b0010);
        send(8'd73, 8'd42, 3'd6, 1'b0, 8'd0,   4'b0001);
        send(8'd73, 8'd42, 3'd7, 1'b0, 8'd0,   4'b0001);
        send(8'd73, 8'd2,  3'd6, 1'b0, 8'd36,  4'b0000);
        send(8'd73, 8'd3,  3'd7, 1'b0, 8'd9,   4'b0000);
        send(8'd200, 8'd100, 3'd0, 1'b0, 8'd44,  4'b0100);
        send(8'd100, 8'd100, 3'd0, 1'b0, 8'd200, 4'b1010);
        send(8'd42, 8'd73, 3'd1, 1'b0, 8'd225, 4'b0110);
        send(8'd73, 8'd73, 3'd1, 1'b0, 8'd0,   4'b0001);
        wait_drain();
        check("outputs_seen", 32'(out_cyc_q.size()), 32'd14);
        if (out_cyc_q.size() == 14 && acc_cyc_q.size() == 14) begin
            check("latency", 32'(out_cyc_q[0] - acc_cyc_q[0]), 32'd2);
            check("throughput_span", 32'(out_cyc_q[13] - out_cyc_q[0]), 32'd13);
        end

        // Accumulator chain.
        do_reset();
        send(8'd90, 8'd5, 3'd0, 1'b1, 8'd5,  4'b0000);
        send(8'd90, 8'd5, 3'd0, 1'b1, 8'd10, 4'b0000);
        send(8'd90, 8'd5, 3'd0, 1'b1, 8'd15, 4'b0000);
        send(8'd255, 8'd15, 3'd2, 1'b0, 8'd15, 4'b0000);
        send(8'd0, 8'd0, 3'd0, 1'b1, 8'd15, 4'b0000);
        wait_drain();

        // Backpressure: only two of four bundles fit while out_ready is low.
        out_ready = 1'b0;
        num_acc = 0;
        bp_done = 1'b0;
        fork
            begin
                send(8'd1, 8'd1, 3'd0, 1'b0, 8'd2, 4'b0000);
                send(8'd2, 8'd2, 3'd0, 1'b0, 8'd4, 4'b0000);
                send(8'd3, 8'd3, 3'd0, 1'b0, 8'd6, 4'b0000);
                send(8'd4, 8'd4, 3'd0, 1'b0, 8'd8, 4'b0000);
                bp_done = 1'b1;
            end
        join_none
        repeat (6) @(negedge clk);
        check("bp_accepted", 32'(num_acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_y_hold", 32'(Y), 32'd2);
        repeat (3) @(negedge clk);
        check("bp_y_hold_later", 32'(Y), 32'd2);
        align();
        out_ready = 1'b1;
        n = 0;
        while (!bp_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_all_sent", 32'(bp_done), 32'd1);
        check("bp_accepted_total", 32'(num_acc), 32'd4);
        wait_drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                send(8'd10, 8'd10, 3'd0, 1'b0, 8'd20, 4'b0000);
                send(8'd20, 8'd20, 3'd0, 1'b0, 8'd40, 4'b0000);
                bp_done = 1'b1;
            end
        join_none
        n = 0;
        while (!bp_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        do_reset();
        out_ready = 1'b1;
        send(8'd99, 8'd7, 3'd0, 1'b1, 8'd7, 4'b0000);
        wait_drain();

        // Random stream against the reference model, random backpressure.
        mdl_acc = 8'd7;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    ra = 8'($urandom_range(0, 255));
                    rb = 8'($urandom_range(0, 12));
                    if ($urandom_range(0, 1) == 1) rb = 8'($urandom_range(0, 255));
                    rop = 3'($urandom_range(0, 7));
                    racc = 1'($urandom_range(0, 1));
                    aeff = racc ? mdl_acc : ra;
                    r = model(aeff, rb, rop);
                    mdl_acc = r[11:4];
                    send(ra, rb, rop, racc, r[11:4], r[3:0]);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
